axi_addr_ch_fifo: RTL and testbench
===================================

Name: axi_addr_ch_fifo

Overview:
Parametrised AXI4-Lite address-channel acceptor: the successor to the single-register ready/busy handshake block. It captures AW or AR beats (address + prot) into a DEPTH-entry FIFO so the master can issue back-to-back addresses while the register-file backend is busy. It sits between the AXI slave port and the GPIO register decode logic, one instance per address channel. oREADY stays registered, as in the previous generation.

Parameters:
ADDR_W, 32, address width in bits (>=3)
DEPTH, 2, FIFO entries; power of two, >=2
PTR_W, $clog2(DEPTH), derived pointer width; not overridden

Ports:
iCLK  input  1  clock, rising edge
iRSTN  input  1  reset, asynchronous, active-low
iADDR  input  ADDR_W  AXI AxADDR
iPROT  input  3  AXI AxPROT
iVALID  input  1  AXI AxVALID
oREADY  output  1  AXI AxREADY, registered
iBUSY  input  1  backend stall; blocks new accepts
oVALID  output  1  head entry valid toward backend
oADDR  output  ADDR_W  head entry address
oPROT  output  3  head entry prot
oERR  output  1  head entry misalignment flag (see Optional Feature)
iPOP  input  1  backend consumes the head entry
oLEVEL  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (iRSTN low, async): count=0, wr/rd pointers=0, oREADY=1, oVALID=0, oLEVEL=0. oADDR/oPROT/oERR=0. Storage contents are don't-care.
- push = iVALID & oREADY. On push, write {iADDR, iPROT, err} at wr_ptr, then wr_ptr++ (wraps modulo DEPTH).
- pop = iPOP & oVALID. On pop, rd_ptr++ (wraps). iPOP while empty is ignored and must not corrupt state.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged, and both pointers advance.
- oREADY is registered: oREADY <= (count_next != DEPTH) & ~iBUSY. Overflow is therefore impossible. A push is never dropped when oREADY=1.
- iBUSY takes effect one cycle later: oREADY falls the cycle after iBUSY rises and rises the cycle after iBUSY falls (provided not full). Entries already held remain poppable while iBUSY=1.
- oVALID = (count != 0). oADDR/oPROT/oERR = entry[rd_ptr], driven from registered state with no input-to-output combinational path.
- Latency: a push in cycle N gives oVALID=1 with that data in cycle N+1. A push into an empty FIFO cannot be popped in the same cycle.
- Full (count=DEPTH): oREADY=0. A pop in that cycle makes oREADY=1 next cycle (if ~iBUSY).
- Empty: oVALID=0. oADDR/oPROT hold the last-read slot value, which has no meaning.
- oLEVEL = count.
- Reset mid-transfer: all pending entries are discarded and the block returns to reset values immediately. No partial state survives.
- AXI rule: oREADY may deassert while iVALID=1. The block relies on the master holding iADDR/iPROT stable until the handshake completes.

Optional Feature:
Macro AXADR_ALIGN_CHK_EN.
- Defined: err = (iADDR[1:0] != 2'b00), stored per entry and presented on oERR with the head entry. The backend uses it to return SLVERR. The entry is still queued normally.
- Undefined: no err storage; oERR tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then idle -> oREADY=1, oVALID=0, oLEVEL=0. Assert iRSTN low mid-run with 2 entries -> oLEVEL=0 and oVALID=0 immediately.
2. DEPTH=2, iBUSY=0, iPOP=0. Push 0x0000_0010/prot 3'b000 then 0x0000_0014/prot 3'b010 -> oLEVEL=2, oREADY=0 after the second accept. A third iVALID is held off. oADDR=0x10.
3. From full, pulse iPOP one cycle -> oADDR=0x14, oPROT=3'b010, oLEVEL=1, oREADY=1 next cycle. The held third address is accepted.
4. Continuous iVALID with iPOP=1 every cycle, 8 addresses 0x00..0x1C -> all popped in order with 1-cycle latency. Pointers wrap cleanly and oLEVEL never exceeds 1.
5. Raise iBUSY in cycle N with oLEVEL=1 -> oREADY=0 from N+1. Pop still drains to oLEVEL=0. Drop iBUSY -> oREADY=1 one cycle later.
6. AXADR_ALIGN_CHK_EN defined, push 0x0000_0012 -> oERR=1 on that head. Push 0x0000_0018 -> oERR=0. Build without the macro -> oERR=0 for both.

Source files
------------

// File: rtl/axi_addr_ch_fifo.sv
// axi_addr_ch_fifo
// AXI4-Lite address-channel acceptor (one instance per AW or AR channel).
// Beats carrying address and prot are queued in a DEPTH-entry FIFO. The
// master can then issue back-to-back addresses while the register-file
// backend is still busy.
//
// Optional feature:
//     AXADR_ALIGN_CHK_EN  Defining this macro stores a per-entry
//                         misalignment flag (iADDR[1:0] != 0) and presents
//                         it on oERR. When the macro is undefined, oERR is
//                         tied to 0.
//
// Ports:
//     iCLK    in   clock, rising edge
//     iRSTN   in   asynchronous active-low reset
//     iADDR   in   AxADDR [ADDR_W-1:0]
//     iPROT   in   AxPROT [2:0]
//     iVALID  in   AxVALID
//     oREADY  out  AxREADY, registered
//     iBUSY   in   backend stall; blocks new accepts one cycle later
//     oVALID  out  head entry valid toward the backend
//     oADDR   out  head entry address
//     oPROT   out  head entry prot
//     oERR    out  head entry misalignment flag
//     iPOP    in   backend consumes the head entry
//     oLEVEL  out  occupancy, 0..DEPTH
module axi_addr_ch_fifo #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              iCLK,
    input  logic              iRSTN,
    input  logic [ADDR_W-1:0] iADDR,
    input  logic [2:0]        iPROT,
    input  logic              iVALID,
    output logic              oREADY,
    input  logic              iBUSY,
    output logic              oVALID,
    output logic [ADDR_W-1:0] oADDR,
    output logic [2:0]        oPROT,
    output logic              oERR,
    input  logic              iPOP,
    output logic [PTR_W:0]    oLEVEL
);

    localparam logic [PTR_W:0] FULL_LEVEL = DEPTH[PTR_W:0];

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [2:0]        prot_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              ready_q;
    logic              push;
    logic              pop;

    // Push is qualified by the registered ready, so a full FIFO can never
    // be written. Pop is qualified by non-empty, so iPOP on an empty FIFO
    // is harmless.
    assign push       = iVALID & ready_q;
    assign pop        = iPOP & (count != '0);
    assign count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    // The storage is reset as well. This makes the head outputs read 0
    // straight out of reset without a separate output register.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                prot_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[wr_ptr] <= iADDR;
            prot_mem[wr_ptr] <= iPROT;
        end
    end

`ifdef AXADR_ALIGN_CHK_EN
    logic err_mem [DEPTH];

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                err_mem[i] <= 1'b0;
            end
        end else if (push) begin
            err_mem[wr_ptr] <= (iADDR[1:0] != 2'b00);
        end
    end

    assign oERR = err_mem[rd_ptr];
`else
    assign oERR = 1'b0;
`endif

    // Ready looks one cycle ahead at the post-update occupancy. It therefore
    // drops in the same edge that fills the FIFO, and iBUSY is seen one
    // cycle late.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            ready_q <= (count_next != FULL_LEVEL) & ~iBUSY;
        end
    end

    assign oREADY = ready_q;
    assign oVALID = (count != '0);
    assign oADDR  = addr_mem[rd_ptr];
    assign oPROT  = prot_mem[rd_ptr];
    assign oLEVEL = count;

endmodule

// File: tb/tb_axi_addr_ch_fifo.sv
// tb_axi_addr_ch_fifo
// Directed bench for axi_addr_ch_fifo with the default parameters
// (ADDR_W=32, DEPTH=2). Inputs change and outputs are sampled 1 ns after
// each rising edge. The expected oERR value depends on AXADR_ALIGN_CHK_EN.
module tb_axi_addr_ch_fifo;

    logic        iCLK;
    logic        iRSTN;
    logic [31:0] iADDR;
    logic [2:0]  iPROT;
    logic        iVALID;
    logic        oREADY;
    logic        iBUSY;
    logic        oVALID;
    logic [31:0] oADDR;
    logic [2:0]  oPROT;
    logic        oERR;
    logic        iPOP;
    logic [1:0]  oLEVEL;

    int assertCount = 0;
    int failCount   = 0;

`ifdef AXADR_ALIGN_CHK_EN
    localparam logic ERR_MISALIGNED = 1'b1;
`else
    localparam logic ERR_MISALIGNED = 1'b0;
`endif

    axi_addr_ch_fifo #(
        .ADDR_W(32),
        .DEPTH (2)
    ) dut (
        .iCLK  (iCLK),
        .iRSTN (iRSTN),
        .iADDR (iADDR),
        .iPROT (iPROT),
        .iVALID(iVALID),
        .oREADY(oREADY),
        .iBUSY (iBUSY),
        .oVALID(oVALID),
        .oADDR (oADDR),
        .oPROT (oPROT),
        .oERR  (oERR),
        .iPOP  (iPOP),
        .oLEVEL(oLEVEL)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Drive one cycle of inputs, then wait until just after the next edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                                 input logic [2:0] prot, input logic pop,
                                 input logic busy);
        iVALID = valid;
        iADDR  = addr;
        iPROT  = prot;
        iPOP   = pop;
        iBUSY  = busy;
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        iRSTN  = 1'b0;
        iVALID = 1'b0;
        iADDR  = '0;
        iPROT  = '0;
        iPOP   = 1'b0;
        iBUSY  = 1'b0;
        #12;
        checkOutput("rst_ready", 32'(oREADY), 32'd1);
        checkOutput("rst_valid", 32'(oVALID), 32'd0);
        checkOutput("rst_level", 32'(oLEVEL), 32'd0);
        checkOutput("rst_addr",  oADDR,       32'h0);
        checkOutput("rst_prot",  32'(oPROT),  32'd0);
        checkOutput("rst_err",   32'(oERR),   32'd0);
        @(negedge iCLK);
        iRSTN = 1'b1;
        @(posedge iCLK);
        #1;

        // Idle with no traffic after reset.
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        checkOutput("idle_ready", 32'(oREADY), 32'd1);
        checkOutput("idle_valid", 32'(oVALID), 32'd0);

        // Fill both entries; the third address is held off.
        applyStimulus(1'b1, 32'h10, 3'b000, 1'b0, 1'b0);
        checkOutput("fill1_level", 32'(oLEVEL), 32'd1);
        checkOutput("fill1_valid", 32'(oVALID), 32'd1);
        checkOutput("fill1_addr",  oADDR,       32'h10);
        checkOutput("fill1_ready", 32'(oREADY), 32'd1);
        applyStimulus(1'b1, 32'h14, 3'b010, 1'b0, 1'b0);
        checkOutput("fill2_level", 32'(oLEVEL), 32'd2);
        checkOutput("fill2_ready", 32'(oREADY), 32'd0);
        checkOutput("fill2_addr",  oADDR,       32'h10);
        applyStimulus(1'b1, 32'h18, 3'b001, 1'b0, 1'b0);
        checkOutput("held_level", 32'(oLEVEL), 32'd2);
        checkOutput("held_ready", 32'(oREADY), 32'd0);
        checkOutput("held_addr",  oADDR,       32'h10);

        // Single pop from full; the held third address then goes in.
        applyStimulus(1'b1, 32'h18, 3'b001, 1'b1, 1'b0);
        checkOutput("pop1_addr",  oADDR,       32'h14);
        checkOutput("pop1_prot",  32'(oPROT),  32'd2);
        checkOutput("pop1_level", 32'(oLEVEL), 32'd1);
        checkOutput("pop1_ready", 32'(oREADY), 32'd1);
        applyStimulus(1'b1, 32'h18, 3'b001, 1'b0, 1'b0);
        checkOutput("acc3_level", 32'(oLEVEL), 32'd2);
        checkOutput("acc3_ready", 32'(oREADY), 32'd0);
        checkOutput("acc3_addr",  oADDR,       32'h14);

        // Drain the FIFO, then pop while empty.
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        checkOutput("drain1_addr", oADDR,      32'h18);
        checkOutput("drain1_prot", 32'(oPROT), 32'd1);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        checkOutput("drain2_valid", 32'(oVALID), 32'd0);
        checkOutput("drain2_level", 32'(oLEVEL), 32'd0);
        checkOutput("drain2_ready", 32'(oREADY), 32'd1);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        checkOutput("emptypop_level", 32'(oLEVEL), 32'd0);
        checkOutput("emptypop_valid", 32'(oVALID), 32'd0);
        checkOutput("emptypop_ready", 32'(oREADY), 32'd1);

        // Streaming with a pop every cycle; the head trails by one edge.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 3'(i), 1'b1, 1'b0);
            checkOutput($sformatf("stream%0d_addr", i),  oADDR,       32'(i * 4));
            checkOutput($sformatf("stream%0d_prot", i),  32'(oPROT),  32'(i % 8));
            checkOutput($sformatf("stream%0d_level", i), 32'(oLEVEL), 32'd1);
            checkOutput($sformatf("stream%0d_ready", i), 32'(oREADY), 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        checkOutput("stream_end_level", 32'(oLEVEL), 32'd0);

        // iBUSY behaviour.
        applyStimulus(1'b1, 32'h40, 3'b000, 1'b0, 1'b0);
        checkOutput("busy_pre_level", 32'(oLEVEL), 32'd1);
        checkOutput("busy_pre_ready", 32'(oREADY), 32'd1);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b1);
        checkOutput("busy_ready", 32'(oREADY), 32'd0);
        checkOutput("busy_level", 32'(oLEVEL), 32'd1);
        applyStimulus(1'b1, 32'h44, 3'b011, 1'b1, 1'b1);
        checkOutput("busy_pop_level", 32'(oLEVEL), 32'd0);
        checkOutput("busy_pop_valid", 32'(oVALID), 32'd0);
        checkOutput("busy_pop_ready", 32'(oREADY), 32'd0);
        applyStimulus(1'b1, 32'h44, 3'b011, 1'b0, 1'b0);
        checkOutput("unbusy_ready", 32'(oREADY), 32'd1);
        checkOutput("unbusy_level", 32'(oLEVEL), 32'd0);
        applyStimulus(1'b1, 32'h44, 3'b011, 1'b0, 1'b0);
        checkOutput("unbusy_acc_level", 32'(oLEVEL), 32'd1);
        checkOutput("unbusy_acc_addr",  oADDR,       32'h44);
        checkOutput("unbusy_acc_prot",  32'(oPROT),  32'd3);

        // Asynchronous reset while two entries are held.
        applyStimulus(1'b1, 32'h48, 3'b000, 1'b0, 1'b0);
        checkOutput("prerst_level", 32'(oLEVEL), 32'd2);
        iVALID = 1'b0;
        iRSTN  = 1'b0;
        #1;
        checkOutput("midrst_level", 32'(oLEVEL), 32'd0);
        checkOutput("midrst_valid", 32'(oVALID), 32'd0);
        checkOutput("midrst_ready", 32'(oREADY), 32'd1);
        checkOutput("midrst_addr",  oADDR,       32'h0);
        @(negedge iCLK);
        iRSTN = 1'b1;
        @(posedge iCLK);
        #1;

        // Alignment flag.
        applyStimulus(1'b1, 32'h12, 3'b000, 1'b0, 1'b0);
        checkOutput("align_mis_addr", oADDR,      32'h12);
        checkOutput("align_mis_err",  32'(oERR),  32'(ERR_MISALIGNED));
        applyStimulus(1'b1, 32'h18, 3'b000, 1'b0, 1'b0);
        checkOutput("align_full_level", 32'(oLEVEL), 32'd2);
        applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        checkOutput("align_ok_addr", oADDR,     32'h18);
        checkOutput("align_ok_err",  32'(oERR), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
